// File: rtl/video_pkg.sv
// Shared constants and helpers for the text-mode video pipeline.
package video_pkg;

    localparam int POS_W          = 10;
    localparam int DEF_COLS       = 64;
    localparam int DEF_ROWS       = 32;
    localparam int DEF_CHAR_W     = 8;
    localparam int DEF_CHAR_H     = 16;
    localparam int DEF_BLINK_LOG2 = 5;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int GLYPH_ROW_W = clog2(DEF_CHAR_H);

endpackage

// File: rtl/video_text_addr.sv
// Screen-memory address generator: scroll origin plus cell offset,
// wrapped into the screen buffer with one conditional subtract.
module video_text_addr
    import video_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int CHAR_W = DEF_CHAR_W,
    parameter int CHAR_H = DEF_CHAR_H,
    parameter int AW     = clog2(COLS * ROWS)
) (
    input  logic [POS_W-1:0] h_pos,
    input  logic [POS_W-1:0] v_pos,
    input  logic [AW-1:0]    base_addr,
    output logic [AW-1:0]    char_a
);

    localparam int CW    = clog2(CHAR_W);
    localparam int RW    = clog2(CHAR_H);
    localparam int TOTAL = COLS * ROWS;
    localparam int SW    = 24;

    logic [SW-1:0] cell_col;
    logic [SW-1:0] cell_row;
    logic [SW-1:0] sum;

    assign cell_col = SW'(h_pos >> CW);
    assign cell_row = SW'(v_pos >> RW);
    assign sum      = SW'(base_addr) + cell_row * SW'(COLS) + cell_col;

    // Only in-area positions are guaranteed to fit one wrap; others are blanked downstream.
    assign char_a = (sum >= SW'(TOTAL)) ? AW'(sum - SW'(TOTAL)) : AW'(sum);

endmodule

// File: rtl/video_text_pipe.sv
// Two-stage text-mode pixel pipeline: H/V position in, pixel and delayed syncs out.
// Define VIDEO_TEXT_CURSOR_BLINK_EN to blink the cursor from a VSYNC frame counter.
module video_text_pipe
    import video_pkg::*;
#(
    parameter int  COLS       = DEF_COLS,
    parameter int  ROWS       = DEF_ROWS,
    parameter int  CHAR_W     = DEF_CHAR_W,
    parameter int  CHAR_H     = DEF_CHAR_H,
    parameter int  BLINK_LOG2 = DEF_BLINK_LOG2,
    localparam int AW         = clog2(COLS * ROWS),
    localparam int RW         = clog2(CHAR_H),
    localparam int GW         = 7 + RW
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             HSYNC_IN,
    input  logic             VSYNC_IN,
    input  logic             HBLANK,
    input  logic             VBLANK,
    input  logic [POS_W-1:0] H_POS,
    input  logic [POS_W-1:0] V_POS,
    input  logic [AW-1:0]    BASE_ADDR,
    input  logic [AW-1:0]    CURSOR_ADDR,
    input  logic             CURSOR_EN,
    input  logic [RW-1:0]    CURSOR_START,
    input  logic [RW-1:0]    CURSOR_END,
    output logic [AW-1:0]    CHAR_A,
    input  logic [7:0]       CHAR,
    output logic [GW-1:0]    CGROM_A,
    input  logic [7:0]       CHAR_DATA,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             OUT
);

    localparam int CW = clog2(CHAR_W);

    video_text_addr #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .CHAR_W (CHAR_W),
        .CHAR_H (CHAR_H),
        .AW     (AW)
    ) u_addr (
        .h_pos     (H_POS),
        .v_pos     (V_POS),
        .base_addr (BASE_ADDR),
        .char_a    (CHAR_A)
    );

    logic area0;
    assign area0 = ((H_POS >> CW) < POS_W'(COLS)) && ((V_POS >> RW) < POS_W'(ROWS));

    // Stage 1: screen memory is being read, glyph address is formed.
    logic [RW-1:0] row1;
    logic [CW-1:0] col1;
    logic          blank1;
    logic          hs1;
    logic          vs1;
    logic          area1;
    logic          hit1;
    logic [RW-1:0] cs1;
    logic [RW-1:0] ce1;

    // Stage 2: glyph row is being read, pixel is selected.
    logic [CW-1:0] col2;
    logic          blank2;
    logic          hs2;
    logic          vs2;
    logic          area2;
    logic          inv2;
    logic          cur2;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            row1   <= '0;
            col1   <= '0;
            blank1 <= 1'b0;
            hs1    <= 1'b0;
            vs1    <= 1'b0;
            area1  <= 1'b0;
            hit1   <= 1'b0;
            cs1    <= '0;
            ce1    <= '0;
            col2   <= '0;
            blank2 <= 1'b0;
            hs2    <= 1'b0;
            vs2    <= 1'b0;
            area2  <= 1'b0;
            inv2   <= 1'b0;
            cur2   <= 1'b0;
        end else begin
            row1   <= V_POS[RW-1:0];
            col1   <= H_POS[CW-1:0];
            blank1 <= HBLANK | VBLANK;
            hs1    <= HSYNC_IN;
            vs1    <= VSYNC_IN;
            area1  <= area0;
            hit1   <= CURSOR_EN && (CHAR_A == CURSOR_ADDR);
            cs1    <= CURSOR_START;
            ce1    <= CURSOR_END;
            col2   <= col1;
            blank2 <= blank1;
            hs2    <= hs1;
            vs2    <= vs1;
            area2  <= area1;
            inv2   <= CHAR[7];
            cur2   <= hit1 && (cs1 <= row1) && (row1 <= ce1);
        end
    end

    assign CGROM_A = {CHAR[6:0], row1};

    logic blink;
`ifdef VIDEO_TEXT_CURSOR_BLINK_EN
    logic [BLINK_LOG2-1:0] frame_cnt;
    logic                  vs_prev;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_cnt <= '0;
            vs_prev   <= 1'b0;
        end else begin
            vs_prev <= VSYNC_IN;
            if (VSYNC_IN && !vs_prev)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Visible during the first half of the counter period.
    assign blink = ~frame_cnt[BLINK_LOG2-1];
`else
    localparam bit BLINK_STEADY = (BLINK_LOG2 >= 0);
    assign blink = BLINK_STEADY;
`endif

    logic [2:0] bit_idx;
    assign bit_idx = 3'd7 - 3'(col2);

    assign HSYNC = hs2;
    assign VSYNC = vs2;
    assign OUT   = area2 && !blank2 && (CHAR_DATA[bit_idx] ^ inv2 ^ (cur2 && blink));

endmodule

// File: tb/tb_video_text_pipe.sv
// Directed bench for video_text_pipe: vector table plus latency, reset, narrow-screen
// and (with VIDEO_TEXT_CURSOR_BLINK_EN) blink sequences.
module tb_video_text_pipe;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        HSYNC_IN, VSYNC_IN, HBLANK, VBLANK;
    logic [9:0]  H_POS, V_POS;
    logic [10:0] BASE_ADDR, CURSOR_ADDR;
    logic        CURSOR_EN;
    logic [3:0]  CURSOR_START, CURSOR_END;
    logic [7:0]  CHAR, CHAR_DATA;
    logic [10:0] CHAR_A, b_char_a;
    logic [10:0] CGROM_A, b_cgrom_a;
    logic        HSYNC, VSYNC, OUT;
    logic        b_hsync, b_vsync, b_out;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    video_text_pipe dut (
        .CLK(CLK), .RESET(RESET), .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
        .HBLANK(HBLANK), .VBLANK(VBLANK), .H_POS(H_POS), .V_POS(V_POS),
        .BASE_ADDR(BASE_ADDR), .CURSOR_ADDR(CURSOR_ADDR), .CURSOR_EN(CURSOR_EN),
        .CURSOR_START(CURSOR_START), .CURSOR_END(CURSOR_END), .CHAR_A(CHAR_A),
        .CHAR(CHAR), .CGROM_A(CGROM_A), .CHAR_DATA(CHAR_DATA),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .OUT(OUT)
    );

    video_text_pipe #(.COLS(40)) dut_b (
        .CLK(CLK), .RESET(RESET), .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN),
        .HBLANK(HBLANK), .VBLANK(VBLANK), .H_POS(H_POS), .V_POS(V_POS),
        .BASE_ADDR(BASE_ADDR), .CURSOR_ADDR(CURSOR_ADDR), .CURSOR_EN(CURSOR_EN),
        .CURSOR_START(CURSOR_START), .CURSOR_END(CURSOR_END), .CHAR_A(b_char_a),
        .CHAR(CHAR), .CGROM_A(b_cgrom_a), .CHAR_DATA(CHAR_DATA),
        .HSYNC(b_hsync), .VSYNC(b_vsync), .OUT(b_out)
    );

    typedef struct {
        logic [9:0]  h, v;
        logic [10:0] base;
        logic        hb, vb, hs, vs;
        logic [10:0] cur;
        logic        cen;
        logic [3:0]  cs, ce;
        logic [7:0]  chr, cd;
        logic [10:0] e_ca, e_cg;
        logic        e_out;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input int h, v, base, hb, vb, hs, vs, cur, cen, cs, ce,
                                input int chr, cd, e_ca, e_cg, e_out);
        vec_t t;
        t.h = 10'(h); t.v = 10'(v); t.base = 11'(base);
        t.hb = 1'(hb); t.vb = 1'(vb); t.hs = 1'(hs); t.vs = 1'(vs);
        t.cur = 11'(cur); t.cen = 1'(cen); t.cs = 4'(cs); t.ce = 4'(ce);
        t.chr = 8'(chr); t.cd = 8'(cd);
        t.e_ca = 11'(e_ca); t.e_cg = 11'(e_cg); t.e_out = 1'(e_out);
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        H_POS = t.h; V_POS = t.v; BASE_ADDR = t.base;
        HBLANK = t.hb; VBLANK = t.vb; HSYNC_IN = t.hs; VSYNC_IN = t.vs;
        CURSOR_ADDR = t.cur; CURSOR_EN = t.cen; CURSOR_START = t.cs; CURSOR_END = t.ce;
        CHAR = t.chr; CHAR_DATA = t.cd;
    endtask

    task automatic apply_vec(input vec_t t, input int idx);
        drive(t);
        #1;
        check($sformatf("v%0d char_a", idx), 32'(CHAR_A), 32'(t.e_ca));
        @(posedge CLK); #1;
        check($sformatf("v%0d cgrom_a", idx), 32'(CGROM_A), 32'(t.e_cg));
        @(posedge CLK); #1;
        check($sformatf("v%0d out", idx), 32'(OUT), 32'(t.e_out));
        check($sformatf("v%0d syncs", idx), 32'({HSYNC, VSYNC}), 32'({t.hs, t.vs}));
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(posedge CLK);
        #1;
    endtask

    initial begin
        //              h    v    base hb vb hs vs cur en cs ce  chr   cd    ca    cg    out
        vecs[0]  = mk(17,  35,  0,   0, 0, 0, 0, 0,  0, 14, 15, 8'h41, 8'h80, 130,  11'h413, 0);
        vecs[1]  = mk(17,  35,  0,   0, 0, 0, 0, 0,  0, 14, 15, 8'h41, 8'h40, 130,  11'h413, 1);
        vecs[2]  = mk(80,  0,   2040,0, 0, 0, 0, 0,  0, 14, 15, 8'h41, 8'h80, 2,    11'h410, 1);
        vecs[3]  = mk(8,   0,   2047,0, 0, 0, 0, 0,  0, 14, 15, 8'h00, 8'h80, 0,    11'h000, 1);
        vecs[4]  = mk(23,  0,   0,   0, 0, 0, 0, 0,  0, 14, 15, 8'h00, 8'h01, 2,    11'h000, 1);
        vecs[5]  = mk(23,  0,   0,   0, 0, 0, 0, 0,  0, 14, 15, 8'h00, 8'h02, 2,    11'h000, 0);
        vecs[6]  = mk(17,  35,  0,   0, 0, 0, 0, 0,  0, 14, 15, 8'hC1, 8'h00, 130,  11'h413, 1);
        vecs[7]  = mk(17,  35,  0,   1, 0, 0, 0, 0,  0, 14, 15, 8'hC1, 8'h00, 130,  11'h413, 0);
        vecs[8]  = mk(17,  35,  0,   0, 1, 0, 0, 0,  0, 14, 15, 8'hC1, 8'h00, 130,  11'h413, 0);
        vecs[9]  = mk(512, 0,   0,   0, 0, 0, 0, 0,  0, 14, 15, 8'hC1, 8'h00, 64,   11'h410, 0);
        vecs[10] = mk(0,   512, 0,   0, 0, 0, 0, 0,  0, 14, 15, 8'hC1, 8'h00, 0,    11'h410, 0);
        vecs[11] = mk(18,  46,  0,   0, 0, 0, 0, 130,1, 14, 15, 8'h41, 8'h00, 130,  11'h41E, 1);
        vecs[12] = mk(18,  47,  0,   0, 0, 0, 0, 130,1, 14, 15, 8'h41, 8'h00, 130,  11'h41F, 1);
        vecs[13] = mk(18,  45,  0,   0, 0, 0, 0, 130,1, 14, 15, 8'h41, 8'h00, 130,  11'h41D, 0);
        vecs[14] = mk(18,  46,  0,   0, 0, 0, 0, 130,0, 14, 15, 8'h41, 8'h00, 130,  11'h41E, 0);
        vecs[15] = mk(18,  46,  0,   0, 0, 0, 0, 131,1, 14, 15, 8'h41, 8'h00, 130,  11'h41E, 0);
        vecs[16] = mk(18,  46,  0,   0, 0, 0, 0, 130,1, 15, 14, 8'h41, 8'h00, 130,  11'h41E, 0);
        vecs[17] = mk(18,  46,  0,   0, 0, 0, 0, 130,1, 14, 15, 8'hC1, 8'h00, 130,  11'h41E, 0);
        vecs[18] = mk(17,  35,  0,   0, 0, 1, 1, 0,  0, 14, 15, 8'hC1, 8'h00, 130,  11'h413, 1);
        vecs[19] = mk(0,   511, 0,   0, 0, 0, 0, 0,  0, 14, 15, 8'h41, 8'h80, 1984, 11'h41F, 1);

        // Reset state
        RESET = 1'b1;
        drive(vecs[18]);
        tick(2);
        check("reset out", 32'(OUT), 32'd0);
        check("reset syncs", 32'({HSYNC, VSYNC}), 32'd0);
        RESET = 1'b0;
        drive(vecs[0]);
        tick(2);

        for (int i = 0; i < 20; i++) apply_vec(vecs[i], i);

        // One-cycle blank/sync pulse lands exactly two cycles later
        drive(vecs[6]);
        tick(2);
        HBLANK = 1'b1; HSYNC_IN = 1'b1;
        tick(1);
        check("lat edge1 out", 32'(OUT), 32'd1);
        check("lat edge1 hsync", 32'(HSYNC), 32'd0);
        HBLANK = 1'b0; HSYNC_IN = 1'b0;
        tick(1);
        check("lat edge2 out", 32'(OUT), 32'd0);
        check("lat edge2 hsync", 32'(HSYNC), 32'd1);
        tick(1);
        check("lat edge3 out", 32'(OUT), 32'd1);
        check("lat edge3 hsync", 32'(HSYNC), 32'd0);

        // Reset mid-line and pipeline refill
        drive(vecs[18]);
        tick(2);
        check("pre-reset out", 32'(OUT), 32'd1);
        RESET = 1'b1;
        tick(1);
        check("midreset out", 32'(OUT), 32'd0);
        check("midreset syncs", 32'({HSYNC, VSYNC}), 32'd0);
        RESET = 1'b0;
        check("release cycle0 out", 32'(OUT), 32'd0);
        tick(1);
        check("release cycle1 out", 32'(OUT), 32'd0);
        check("release cycle1 hsync", 32'(HSYNC), 32'd0);
        tick(1);
        check("release cycle2 out", 32'(OUT), 32'd1);
        check("release cycle2 hsync", 32'(HSYNC), 32'd1);

        // 40-column screen: cells past column 39 are blank
        drive(vecs[6]);
        V_POS = 10'd16;
        for (int h = 319; h <= 327; h++) begin
            H_POS = 10'(h);
            #1;
            if (h == 319) check("cols40 char_a", 32'(b_char_a), 32'd79);
            tick(2);
            check($sformatf("cols40 h%0d out", h), 32'(b_out), (h == 319) ? 32'd1 : 32'd0);
            if (h == 320) check("cols64 h320 out", 32'(OUT), 32'd1);
        end

`ifdef VIDEO_TEXT_CURSOR_BLINK_EN
        // Blink: frames 0..15 visible, 16..31 hidden, wraps at 32
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        drive(vecs[11]);
        tick(2);
        check("blink frame0", 32'(OUT), 32'd1);
        for (int f = 1; f <= 32; f++) begin
            VSYNC_IN = 1'b1;
            tick(1);
            VSYNC_IN = 1'b0;
            tick(2);
            if (f == 15) check("blink frame15", 32'(OUT), 32'd1);
            if (f == 16) check("blink frame16", 32'(OUT), 32'd0);
            if (f == 31) check("blink frame31", 32'(OUT), 32'd0);
            if (f == 32) check("blink frame32 wrap", 32'(OUT), 32'd1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
